// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALUOp groups and datapath mux select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // ALUOp groups must line up with the ALU control decoder
  localparam logic [2:0] ALUOP_NONE  = 3'b000;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_LOGIC = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b011;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_J   = 3'd4,
    CLS_ILL = 3'd5
  } op_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: instruction class plus the ALUOp used
// by the I-type execute step.
module mc_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_alu_op
);

  always_comb begin
    op_class   = CLS_ILL;
    imm_alu_op = ALUOP_ADD;
    case (opcode)
      OP_R:    op_class = CLS_R;
      OP_J:    op_class = CLS_J;
      OP_ADDI: op_class = CLS_I;
      OP_ANDI: begin op_class = CLS_I; imm_alu_op = ALUOP_LOGIC; end
      OP_ORI:  begin op_class = CLS_I; imm_alu_op = ALUOP_LOGIC; end
      OP_LUI:  begin op_class = CLS_I; imm_alu_op = ALUOP_LUI;   end
      OP_LW:   op_class = CLS_LW;
      OP_SW:   op_class = CLS_SW;
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: time-shares the ALU across fetch, address generation
// and execute, and handshakes with the unified memory.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state_reg, state_next;
  op_class_t  op_class;
  logic [2:0] imm_alu_op;

  mc_opcode_decode u_decode (
    .opcode     (opcode),
    .op_class   (op_class),
    .imm_alu_op (imm_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_NONE;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_class)
          CLS_R:          state_next = S_EXEC_R;
          CLS_I:          state_next = S_EXEC_I;
          CLS_LW, CLS_SW: state_next = S_MEM_ADDR;
          CLS_J:          state_next = S_JUMP;
          default:        state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_RTYPE;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = imm_alu_op;
        state_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = (op_class == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: state_next = S_FETCH;
    endcase

    // A reset cycle abandons the instruction: no request, write or retirement
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = PCSRC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALUOP_NONE;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state_dbg = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus queues per-cycle expected output vectors and
// retirement latencies; a negedge monitor pops and compares them.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int start_cyc = 0;

  logic [21:0] exp_q[$];
  string       tag_q[$];
  int          lat_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  function automatic logic [21:0] ev(
    input logic [3:0] st, input logic req, input logic we, input logic iod,
    input logic irw, input logic pcw, input logic [1:0] pcs, input logic asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic rw, input logic rd,
    input logic m2r, input logic dn, input logic ill);
    return {st, req, we, iod, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, dn, ill};
  endfunction

  wire [21:0] obs = {state_dbg, mem_req, mem_we, i_or_d, ir_write, pc_write,
                     pc_source, alu_src_a, alu_src_b, alu_op, reg_write,
                     reg_dst, mem_to_reg, instr_done, illegal_op};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: outputs got %b required %b", t, cyc, obs, e);
      end
    end
    if (reset) start_cyc = cyc + 1;
    else if (instr_done) begin
      checks++;
      if (lat_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done cycle %0d: got instr_done=1 required 0", cyc);
      end else begin
        int l;
        string n;
        l = lat_q.pop_front();
        n = name_q.pop_front();
        if (cyc - start_cyc + 1 != l) begin
          fails++;
          $display("FAIL %s_latency: got %0d cycles required %0d", n, cyc - start_cyc + 1, l);
        end else
          $display("retired %s latency %0d cycles", n, l);
      end
      start_cyc = cyc + 1;
    end
    cyc++;
  end

  task automatic step(input logic r, input logic mr, input string tag, input logic [21:0] e);
    reset = r;
    mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input string n, input int l);
    lat_q.push_back(l);
    name_q.push_back(n);
  endtask

  logic [21:0] v_fw, v_fr, v_dec, v_exr, v_rwb, v_exi_add, v_exi_log, v_exi_lui;
  logic [21:0] v_iwb, v_ma, v_mrd, v_mwb, v_mwr, v_mwr_done, v_jmp, v_trap;

  initial begin
    v_fw       = ev(S_FETCH,   1,0,0,0,0,2'b00,0,2'b01,3'b100,0,0,0,0,0);
    v_fr       = ev(S_FETCH,   1,0,0,1,1,2'b00,0,2'b01,3'b100,0,0,0,0,0);
    v_dec      = ev(S_DECODE,  0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0);
    v_exr      = ev(S_EXEC_R,  0,0,0,0,0,2'b00,1,2'b00,3'b111,0,0,0,0,0);
    v_rwb      = ev(S_R_WB,    0,0,0,0,0,2'b00,0,2'b00,3'b000,1,1,0,1,0);
    v_exi_add  = ev(S_EXEC_I,  0,0,0,0,0,2'b00,1,2'b10,3'b100,0,0,0,0,0);
    v_exi_log  = ev(S_EXEC_I,  0,0,0,0,0,2'b00,1,2'b10,3'b101,0,0,0,0,0);
    v_exi_lui  = ev(S_EXEC_I,  0,0,0,0,0,2'b00,1,2'b10,3'b011,0,0,0,0,0);
    v_iwb      = ev(S_I_WB,    0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,1,0);
    v_ma       = ev(S_MEM_ADDR,0,0,0,0,0,2'b00,1,2'b10,3'b100,0,0,0,0,0);
    v_mrd      = ev(S_MEM_RD,  1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0);
    v_mwb      = ev(S_MEM_WB,  0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,1,0);
    v_mwr      = ev(S_MEM_WR,  1,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0);
    v_mwr_done = ev(S_MEM_WR,  1,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,1,0);
    v_jmp      = ev(S_JUMP,    0,0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,1,0);
    v_trap     = ev(S_TRAP,    0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,1);

    reset = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    @(posedge clk); #1;
    step(1, 1, "reset", ev(S_FETCH,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0));

    // ADD, zero wait
    opcode = OP_R; retire("add", 4);
    step(0,1,"add_fetch",v_fr); step(0,1,"add_decode",v_dec);
    step(0,1,"add_exec",v_exr); step(0,1,"add_wb",v_rwb);

    // LW: 2 waits in FETCH, 3 in MEM_RD
    opcode = OP_LW; retire("lw", 10);
    step(0,0,"lw_fetch_wait",v_fw); step(0,0,"lw_fetch_wait",v_fw);
    step(0,1,"lw_fetch",v_fr); step(0,1,"lw_decode",v_dec); step(0,1,"lw_addr",v_ma);
    for (int i = 0; i < 3; i++) step(0,0,"lw_rd_wait",v_mrd);
    step(0,1,"lw_rd",v_mrd); step(0,1,"lw_wb",v_mwb);

    // ORI then LUI back to back, then ADDI
    opcode = OP_ORI; retire("ori", 4);
    step(0,1,"ori_fetch",v_fr); step(0,1,"ori_decode",v_dec);
    step(0,1,"ori_exec",v_exi_log); step(0,1,"ori_wb",v_iwb);
    opcode = OP_LUI; retire("lui", 4);
    step(0,1,"lui_fetch",v_fr); step(0,1,"lui_decode",v_dec);
    step(0,1,"lui_exec",v_exi_lui); step(0,1,"lui_wb",v_iwb);
    opcode = OP_ADDI; retire("addi", 4);
    step(0,1,"addi_fetch",v_fr); step(0,1,"addi_decode",v_dec);
    step(0,1,"addi_exec",v_exi_add); step(0,1,"addi_wb",v_iwb);

    // SW with one wait in MEM_WR
    opcode = OP_SW; retire("sw", 5);
    step(0,1,"sw_fetch",v_fr); step(0,1,"sw_decode",v_dec); step(0,1,"sw_addr",v_ma);
    step(0,0,"sw_wr_wait",v_mwr); step(0,1,"sw_wr",v_mwr_done);

    // J
    opcode = OP_J; retire("j", 3);
    step(0,1,"j_fetch",v_fr); step(0,1,"j_decode",v_dec); step(0,1,"j_jump",v_jmp);

    // SW abandoned by reset while waiting in MEM_WR
    opcode = OP_SW;
    step(0,1,"swrst_fetch",v_fr); step(0,1,"swrst_decode",v_dec); step(0,1,"swrst_addr",v_ma);
    step(0,0,"swrst_wr_wait",v_mwr);
    step(1,1,"swrst_reset",ev(S_MEM_WR,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0));
    opcode = OP_J; retire("j_after_reset", 3);
    step(0,1,"jr_fetch",v_fr); step(0,1,"jr_decode",v_dec); step(0,1,"jr_jump",v_jmp);

    // Illegal opcode traps until reset
    opcode = 6'b111111;
    step(0,1,"ill_fetch",v_fr); step(0,1,"ill_decode",v_dec);
    for (int i = 0; i < 20; i++) step(0, i[0], "trap_hold", v_trap);
    step(1,1,"trap_reset",ev(S_TRAP,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0));
    opcode = OP_R; retire("add_after_trap", 5);
    step(0,0,"rst_fetch_wait",v_fw); step(0,1,"rst_fetch",v_fr);
    step(0,1,"rst_decode",v_dec); step(0,1,"rst_exec",v_exr); step(0,1,"rst_wb",v_rwb);

    step(0,0,"idle_fetch",v_fw);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d vectors/%0d retirements pending required 0/0",
               exp_q.size(), lat_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
